// File: rtl/interrupt_ctrl.sv
// Fixed-priority interrupt controller: per-channel sync/edge/pending lanes feeding a
// three-state request handshake (IDLE -> REQ -> SERVICE) toward the CPU.

module irq_chan (
    input  logic clk,
    input  logic rstn,
    input  logic irq,
    input  logic edge_mode,
    input  logic w1c,
    input  logic w1s,
    input  logic ack_clr,
    output logic pend
);
    logic s1, s2, s3, pend_q;

    // Set terms are OR'd in after clears so a same-cycle edge/W1S beats a W1C or ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            s1     <= irq;
            s2     <= s1;
            s3     <= s2;
            pend_q <= (pend_q & ~(w1c | (ack_clr & edge_mode)))
                    | (edge_mode & s2 & ~s3) | w1s;
        end
    end

    // Level mode follows the synchronised line; pend_q there only holds software sets.
    assign pend = pend_q | (~edge_mode & s2);
endmodule

module interrupt_ctrl #(
    parameter int                N_CH     = 4,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] VEC_BASE = 8'hF0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N_CH-1:0]   irq_in,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    output logic              int_sig,
    output logic [DATA_W-1:0] int_vec,
    output logic [2:0]        int_id,
    input  logic              int_ack,
    input  logic              int_done
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state;
    logic [N_CH-1:0] mask_q, edge_q, pend, cand, w1c, w1s, gnt_oh, ack_clr;
    logic            win_vld, gnt_cand;
    logic [2:0]      win_id;
    logic            unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    assign w1c     = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[N_CH-1:0] : '0;
    assign w1s     = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata[N_CH-1:0] : '0;
    assign gnt_oh  = N_CH'(1) << int_id;
    assign ack_clr = (state == REQ && int_ack) ? gnt_oh : '0;

    irq_chan u_chan [N_CH-1:0] (
        .clk       (clk),
        .rstn      (rstn),
        .irq       (irq_in),
        .edge_mode (edge_q),
        .w1c       (w1c),
        .w1s       (w1s),
        .ack_clr   (ack_clr),
        .pend      (pend)
    );

    assign cand     = pend & ~mask_q;
    assign gnt_cand = |(cand & gnt_oh);

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_vld = 1'b1;
                win_id  = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask_q <= '1;
            edge_q <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0:    mask_q <= cfg_wdata[N_CH-1:0];
                2'd1:    edge_q <= cfg_wdata[N_CH-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0:    cfg_rdata[N_CH-1:0] = mask_q;
            2'd1:    cfg_rdata[N_CH-1:0] = edge_q;
            default: cfg_rdata[N_CH-1:0] = pend;
        endcase
    end

    // Ack takes precedence over a same-cycle loss of candidacy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            int_sig <= 1'b0;
            int_vec <= '0;
            int_id  <= '0;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    state   <= REQ;
                    int_sig <= 1'b1;
                    int_id  <= win_id;
                    int_vec <= VEC_BASE + DATA_W'(win_id);
                end
                REQ: if (int_ack) begin
                    state   <= SERVICE;
                    int_sig <= 1'b0;
                end else if (!gnt_cand) begin
                    state   <= IDLE;
                    int_sig <= 1'b0;
                end
                SERVICE: if (int_done) state <= IDLE;
                default: begin
                    state   <= IDLE;
                    int_sig <= 1'b0;
                end
            endcase
        end
    end
endmodule
